// File: rtl/imu_spi_aggregator.sv
// imu_spi_aggregator: mode-0 SPI slave that captures N_CH IMU MISO lines in parallel and streams them back.
// Define IMU_AGG_CRC8_EN to append a CRC-8 (poly 0x07) trailer to every readout.
`timescale 1ns/1ps
module imu_spi_aggregator #(
    parameter int unsigned N_CH         = 32,
    parameter int unsigned CAPTURE_BITS = 128,
    parameter logic [7:0]  CMD_CAPTURE  = 8'hB0,
    parameter logic [7:0]  CMD_READ     = 8'h90
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs_n,
    input  logic            mosi,
    output logic            miso,
    input  logic [N_CH-1:0] imu_miso,
    output logic            frame_valid,
    output logic            err_cmd,
    output logic            led_cmd,
    output logic            led_load,
    output logic            led_send
);

    localparam int unsigned PAYLOAD_BITS = N_CH * CAPTURE_BITS;
`ifdef IMU_AGG_CRC8_EN
    localparam int unsigned TAIL_BITS = 8;
`else
    localparam int unsigned TAIL_BITS = 0;
`endif
    localparam int unsigned CW = $clog2(PAYLOAD_BITS + 8) + 1;
    localparam int unsigned PW = $clog2(PAYLOAD_BITS);

    localparam logic [CW-1:0] CMD_LAST = CW'(7);
    localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_BITS - 1);
    localparam logic [CW-1:0] CAP_END  = CW'(CAPTURE_BITS);
    localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0] PAY_END  = CW'(PAYLOAD_BITS);
    localparam logic [CW-1:0] RD_END   = CW'(PAYLOAD_BITS + TAIL_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CAPTURE,
        S_READ,
        S_DISCARD
    } state_t;

    state_t state, state_next;

    logic [2:0]      sclk_sr;
    logic [1:0]      cs_sr;
    logic [1:0]      mosi_sr;
    logic [N_CH-1:0] imu_s1;
    logic [N_CH-1:0] imu_s2;

    logic sclk_rise, sclk_fall, cs_high, mosi_s;

    logic          armed;
    logic [6:0]    cmd_sr;
    logic [7:0]    cmd_byte;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] cap_cnt;
    logic [CW-1:0] rd_idx;
    logic          rd_seen;

    logic cap_start, cap_shift, rd_start, rd_adv, err_set;

    // Channel 0 occupies the top of the flattened vector, so payload bit i is payload[P-1-i].
    logic [0:N_CH-1][CAPTURE_BITS-1:0] cap_buf;
    logic [PAYLOAD_BITS-1:0]           payload;
    logic [PW-1:0]                     pay_pos;

    assign payload = cap_buf;

    // cs_n stage resets low so that a host still holding cs_n after rst is not mistaken for a fresh select.
    always_ff @(posedge clock) begin
        if (rst) begin
            sclk_sr <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            imu_s1  <= '0;
            imu_s2  <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[0], cs_n};
            mosi_sr <= {mosi_sr[0], mosi};
            imu_s1  <= imu_miso;
            imu_s2  <= imu_s1;
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_high   = cs_sr[1];
    assign mosi_s    = mosi_sr[1];
    assign cmd_byte  = {cmd_sr, mosi_s};

    always_comb begin
        state_next = state;
        cap_start  = 1'b0;
        cap_shift  = 1'b0;
        rd_start   = 1'b0;
        rd_adv     = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cs_high && armed) state_next = S_CMD;
            end
            S_CMD: begin
                if (cs_high) begin
                    state_next = S_IDLE;
                end else if (sclk_rise && bit_cnt == CMD_LAST) begin
                    if (cmd_byte == CMD_CAPTURE) begin
                        state_next = S_CAPTURE;
                        cap_start  = 1'b1;
                    end else if (cmd_byte == CMD_READ) begin
                        state_next = S_READ;
                        rd_start   = 1'b1;
                    end else begin
                        state_next = S_DISCARD;
                        err_set    = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (cs_high) state_next = S_IDLE;
                else if (sclk_rise && cap_cnt != CAP_END) cap_shift = 1'b1;
            end
            S_READ: begin
                // The fall closing the command byte precedes any host sample, so only falls after a rise advance.
                if (cs_high) state_next = S_IDLE;
                else if (sclk_fall && rd_seen && rd_idx != RD_END) rd_adv = 1'b1;
            end
            S_DISCARD: begin
                if (cs_high) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= S_IDLE;
            armed       <= 1'b0;
            cmd_sr      <= '0;
            bit_cnt     <= '0;
            cap_cnt     <= '0;
            rd_idx      <= '0;
            rd_seen     <= 1'b0;
            frame_valid <= 1'b0;
            err_cmd     <= 1'b0;
        end else begin
            state   <= state_next;
            err_cmd <= err_set;
            if (cs_high) armed <= 1'b1;

            if (state != S_CMD) begin
                bit_cnt <= '0;
            end else if (sclk_rise && !cs_high) begin
                bit_cnt <= bit_cnt + 1'b1;
                cmd_sr  <= cmd_byte[6:0];
            end

            if (cap_start) begin
                frame_valid <= 1'b0;
                cap_cnt     <= '0;
            end else if (cap_shift) begin
                cap_cnt <= cap_cnt + 1'b1;
                if (cap_cnt == CAP_LAST) frame_valid <= 1'b1;
            end

            if (rd_start) begin
                rd_idx  <= '0;
                rd_seen <= 1'b0;
            end else begin
                if (state == S_READ && sclk_rise && !cs_high) rd_seen <= 1'b1;
                if (rd_adv) rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (cap_shift) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                cap_buf[ch] <= {cap_buf[ch][CAPTURE_BITS-2:0], imu_s2[ch]};
            end
        end
    end

`ifdef IMU_AGG_CRC8_EN
    logic [N_CH-1:0][7:0] crc_ch;
    logic [7:0]           crc_total;
    logic [2:0]           crc_pos;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    always_ff @(posedge clock) begin
        if (cap_start) begin
            crc_ch <= '0;
        end else if (cap_shift) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                crc_ch[ch] <= crc_step(crc_ch[ch], imu_s2[ch]);
            end
        end
    end

    // Per-channel CRCs are stitched into the channel-major stream CRC by linearity:
    // advance the running value over CAPTURE_BITS zero bits, then fold in the next channel.
    always_comb begin
        crc_total = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            for (int unsigned b = 0; b < CAPTURE_BITS; b++) begin
                crc_total = crc_step(crc_total, 1'b0);
            end
            crc_total = crc_total ^ crc_ch[ch];
        end
    end

    assign crc_pos = 3'(rd_idx - PAY_END);
`endif

    assign pay_pos = PW'(PAY_LAST - rd_idx);

    always_comb begin
        miso = 1'b0;
        if (state == S_READ && frame_valid) begin
            if (rd_idx < PAY_END) begin
                miso = payload[pay_pos];
            end
`ifdef IMU_AGG_CRC8_EN
            else if (rd_idx < RD_END) begin
                miso = crc_total[3'd7 - crc_pos];
            end
`endif
        end
    end

    assign led_cmd  = (state == S_CMD);
    assign led_load = (state == S_CAPTURE);
    assign led_send = (state == S_READ);

endmodule

// File: tb/tb_imu_spi_aggregator.sv
// Scoreboard bench for imu_spi_aggregator (N_CH=4, CAPTURE_BITS=8, clock = 10x SCLK).
// Honours IMU_AGG_CRC8_EN so the expected readout tail matches the build.
`timescale 1ns/1ps
module tb_imu_spi_aggregator;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CB   = 8;
    localparam int          P    = N_CH * CB;
    localparam logic [7:0]  CMD_CAPTURE = 8'hB0;
    localparam logic [7:0]  CMD_READ    = 8'h90;

    logic            clock = 1'b0;
    logic            rst   = 1'b1;
    logic            sclk  = 1'b0;
    logic            cs_n  = 1'b1;
    logic            mosi  = 1'b0;
    logic [N_CH-1:0] imu_miso = '0;
    logic            miso, frame_valid, err_cmd, led_cmd, led_load, led_send;

    int checks = 0;
    int errors = 0;

    logic          exp_q[$];
    logic          exp_b;
    logic          mon_en = 1'b0;
    int            mon_idx = 0;
    int            err_cycles = 0;

    logic [CB-1:0] model_buf [N_CH];
    logic          model_valid = 1'b0;
    logic [CB-1:0] cap_data  [N_CH];

    imu_spi_aggregator #(
        .N_CH(N_CH),
        .CAPTURE_BITS(CB),
        .CMD_CAPTURE(CMD_CAPTURE),
        .CMD_READ(CMD_READ)
    ) dut (
        .clock(clock),
        .rst(rst),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .imu_miso(imu_miso),
        .frame_valid(frame_valid),
        .err_cmd(err_cmd),
        .led_cmd(led_cmd),
        .led_load(led_load),
        .led_send(led_send)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Reference: the payload is the captured bytes laid end to end, channel 0 first, MSB first.
    function automatic logic model_payload_bit(input int i);
        logic [CB-1:0] byte_v;
        byte_v = model_buf[i / CB];
        return byte_v[CB - 1 - (i % CB)];
    endfunction

    function automatic logic [7:0] model_crc();
        logic [7:0] c;
        logic       b;
        c = 8'h00;
        for (int i = 0; i < P; i++) begin
            b = model_payload_bit(i);
            if (c[7] ^ b) c = {c[6:0], 1'b0} ^ 8'h07;
            else          c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic exp_bit(input int i);
        logic [7:0] crc;
        crc = model_crc();
        if (!model_valid) return 1'b0;
        if (i < P) return model_payload_bit(i);
`ifdef IMU_AGG_CRC8_EN
        if (i < P + 8) return crc[7 - (i - P)];
`endif
        return crc[0] & 1'b0;
    endfunction

    // Scoreboard monitor: the host samples miso on every SCLK rise inside a data window.
    always @(posedge sclk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso_unexpected_sample[%0d]: got %0b expected no sample", mon_idx, miso);
            end else begin
                exp_b = exp_q.pop_front();
                check("miso", mon_idx, {31'd0, miso}, {31'd0, exp_b});
            end
            mon_idx++;
        end
    end

    always @(negedge clock) begin
        if (err_cmd === 1'b1) err_cycles++;
    end

    task automatic sclk_cycle(input logic mosi_v, input logic [N_CH-1:0] imu_v);
        mosi     = mosi_v;
        imu_miso = imu_v;
        repeat (5) @(negedge clock);
        sclk = 1'b1;
        repeat (5) @(negedge clock);
        sclk = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clock);
        cs_n = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (3) @(negedge clock);
        cs_n = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        for (int i = 7; i >= 0; i--) sclk_cycle(cmd[i], N_CH'($urandom));
    endtask

    task automatic do_capture(input int nrises);
        logic [N_CH-1:0] v;
        cs_begin();
        check("led_cmd_in_cmd", nrises, {31'd0, led_cmd}, 32'd1);
        send_cmd(CMD_CAPTURE);
        check("led_load_in_capture", nrises, {31'd0, led_load}, 32'd1);
        check("frame_valid_cleared", nrises, {31'd0, frame_valid}, 32'd0);
        for (int r = 0; r < nrises; r++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (r < CB) v[ch] = cap_data[ch][CB - 1 - r];
                else        v[ch] = 1'($urandom);
            end
            sclk_cycle(1'($urandom), v);
        end
        cs_end();
        if (nrises >= CB) begin
            for (int ch = 0; ch < N_CH; ch++) model_buf[ch] = cap_data[ch];
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        check("frame_valid_after_capture", nrises, {31'd0, frame_valid}, {31'd0, model_valid});
    endtask

    task automatic do_read(input int nclk);
        int send_low;
        send_low = 0;
        cs_begin();
        send_cmd(CMD_READ);
        for (int i = 0; i < nclk; i++) exp_q.push_back(exp_bit(i));
        mon_idx = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < nclk; i++) begin
            sclk_cycle(1'($urandom), N_CH'($urandom));
            if (led_send !== 1'b1) send_low++;
        end
        mon_en = 1'b0;
        check("led_send_low_cycles", nclk, send_low, 0);
        check("exp_q_left", nclk, exp_q.size(), 0);
        cs_end();
        check("led_send_after_cs", nclk, {31'd0, led_send}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_before;
        int cmd_seen;

        // 1. Reset with random pin activity.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            sclk = 1'($urandom); cs_n = 1'($urandom); mosi = 1'($urandom); imu_miso = N_CH'($urandom);
            @(negedge clock);
            check("reset_miso", c, {31'd0, miso}, 32'd0);
            check("reset_frame_valid", c, {31'd0, frame_valid}, 32'd0);
            check("reset_err_cmd", c, {31'd0, err_cmd}, 32'd0);
            check("reset_leds", c, {29'd0, led_cmd, led_load, led_send}, 32'd0);
        end
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (6) @(negedge clock);
        check("idle_leds", 0, {29'd0, led_cmd, led_load, led_send}, 32'd0);

        // 2. Full capture of A5 3C FF 00, then a 32-clock read.
        cap_data[0] = 8'hA5; cap_data[1] = 8'h3C; cap_data[2] = 8'hFF; cap_data[3] = 8'h00;
        do_capture(CB);
        do_read(P);

        // 4. Unknown command: single err pulse, silent miso, frame_valid kept.
        err_before = err_cycles;
        cs_begin();
        send_cmd(8'h55);
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        mon_idx = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < 16; i++) sclk_cycle(1'($urandom), N_CH'($urandom));
        mon_en = 1'b0;
        cs_end();
        check("err_cmd_pulse_cycles", 0, err_cycles - err_before, 1);
        check("frame_valid_after_discard", 0, {31'd0, frame_valid}, {31'd0, model_valid});

        // 5. Same data, 48-clock read covers the tail.
        do_read(48);

        // 3. Aborted capture after 4 rises, then read returns zeros.
        for (int ch = 0; ch < N_CH; ch++) cap_data[ch] = CB'($urandom);
        do_capture(4);
        do_read(P);

        // 6. Reset in the middle of a read.
        cap_data[0] = 8'hA5; cap_data[1] = 8'h3C; cap_data[2] = 8'hFF; cap_data[3] = 8'h00;
        do_capture(CB);
        cs_begin();
        send_cmd(CMD_READ);
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_bit(i));
        mon_idx = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < 10; i++) sclk_cycle(1'($urandom), N_CH'($urandom));
        mon_en = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        model_valid = 1'b0;
        check("rst_mid_read_miso", 0, {31'd0, miso}, 32'd0);
        check("rst_mid_read_frame_valid", 0, {31'd0, frame_valid}, 32'd0);
        check("rst_mid_read_leds", 0, {29'd0, led_cmd, led_load, led_send}, 32'd0);
        cmd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            sclk_cycle(CMD_CAPTURE[7 - i], N_CH'($urandom));
            if (led_cmd !== 1'b0 || led_load !== 1'b0) cmd_seen++;
        end
        check("no_cmd_without_reselect", 0, cmd_seen, 0);
        cs_end();
        for (int ch = 0; ch < N_CH; ch++) cap_data[ch] = CB'($urandom);
        do_capture(CB);
        do_read(P);

        // Randomised rounds: extra ignored rises, variable read lengths, repeated reads.
        for (int round = 0; round < 3; round++) begin
            for (int ch = 0; ch < N_CH; ch++) cap_data[ch] = CB'($urandom);
            do_capture(CB + int'($urandom_range(0, 2)));
            do_read(int'($urandom_range(P, P + 12)));
            do_read(P);
        end

        check("err_cmd_total_cycles", 0, err_cycles, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
